// File: rtl/rx_port_pkg.sv
// Shared types and constants for the rx_port read-request splitter.
package rx_port_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StWaitSpace,
        StReq,
        StAcked,
        StHold
    } state_e;

    localparam int unsigned MAX_READ_CAP = 4;
    localparam int unsigned WORD_BYTES   = 4;
    localparam int unsigned PAGE_WORDS   = 1024;

    // Largest read in words for a MAX_READ code; codes above the cap saturate at 512 words.
    function automatic logic [9:0] max_read_words(input logic [2:0] max_read);
        logic [2:0] cap;
        cap = (max_read > 3'(MAX_READ_CAP)) ? 3'(MAX_READ_CAP) : max_read;
        return 10'd32 << cap;
    endfunction

endpackage

// File: rtl/rx_req_len_calc.sv
// Chunk length: min(remaining, max read size, words to the next 4 KB page).
// The page-boundary term is only active when RXREQ_SPLIT_4K_EN is defined.
module rx_req_len_calc
    import rx_port_pkg::*;
(
    input  logic [30:0] remaining,
    input  logic [2:0]  max_read,
    input  logic [9:0]  page_ofs,
    output logic [9:0]  chunk
);

`ifdef RXREQ_SPLIT_4K_EN
    localparam bit Split4kEn = 1'b1;
`else
    localparam bit Split4kEn = 1'b0;
`endif

    logic [10:0] to_boundary;
    logic [10:0] max_words;
    logic [9:0]  lim;

    always_comb begin
        to_boundary = Split4kEn ? (11'(PAGE_WORDS) - {1'b0, page_ofs}) : 11'(PAGE_WORDS);
        max_words   = {1'b0, max_read_words(max_read)};
        // max_words never exceeds 512, so the 10-bit limit cannot truncate
        lim         = (to_boundary < max_words) ? to_boundary[9:0] : max_words[9:0];
        chunk       = (remaining < 31'(lim)) ? remaining[9:0] : lim;
    end

endmodule

// File: rtl/rx_port_read_splitter.sv
// Splits a host-buffer transfer descriptor into space-gated read requests for the
// rx_port MAIN channel. Optional 4 KB splitting is controlled by RXREQ_SPLIT_4K_EN.
module rx_port_read_splitter
    import rx_port_pkg::*;
#(
    parameter int unsigned SpaceLat = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        xfer_start,
    input  logic [63:0] xfer_addr,
    input  logic [30:0] xfer_len,
    input  logic        xfer_abort,
    input  logic [2:0]  max_read,
    input  logic [15:0] space_avail,
    output logic        main_req,
    output logic [9:0]  main_len,
    output logic [63:0] main_addr,
    input  logic        main_req_proc,
    output logic        xfer_busy,
    output logic        xfer_done,
    output logic [30:0] xfer_req_words
);

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [30:0] rem_q, rem_d;
    logic [9:0]  chunk_q, chunk_d;
    logic [30:0] req_words_q, req_words_d;
    logic        main_req_q, main_req_d;
    logic [9:0]  main_len_q, main_len_d;
    logic [63:0] main_addr_q, main_addr_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [9:0]  calc_chunk;

    rx_req_len_calc u_len_calc (
        .remaining (rem_q),
        .max_read  (max_read),
        .page_ofs  (addr_q[11:2]),
        .chunk     (calc_chunk)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        chunk_d     = chunk_q;
        req_words_d = req_words_q;
        main_req_d  = main_req_q;
        main_len_d  = main_len_q;
        main_addr_d = main_addr_q;
        done_d      = 1'b0;
        abort_d     = abort_q;
        hold_cnt_d  = hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                if (xfer_abort) begin
                    done_d = 1'b1;
                end else if (xfer_start) begin
                    addr_d      = xfer_addr & ~64'h3;
                    rem_d       = xfer_len;
                    req_words_d = '0;
                    if (xfer_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (xfer_abort) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    chunk_d = calc_chunk;
                    state_d = StWaitSpace;
                end
            end
            StWaitSpace: begin
                if (xfer_abort) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (space_avail >= {6'b0, chunk_q}) begin
                    main_req_d  = 1'b1;
                    main_addr_d = addr_q;
                    main_len_d  = chunk_q;
                    state_d     = StReq;
                end
            end
            StReq: begin
                // Once presented, a request is never withdrawn; abort waits for the handshake
                abort_d = abort_q | xfer_abort;
                if (main_req_proc) begin
                    main_req_d  = 1'b0;
                    addr_d      = addr_q + 64'(chunk_q) * 64'(WORD_BYTES);
                    rem_d       = rem_q - 31'(chunk_q);
                    req_words_d = req_words_q + 31'(chunk_q);
                    state_d     = StAcked;
                end
            end
            StAcked: begin
                abort_d = abort_q | xfer_abort;
                if (!main_req_proc) begin
                    if (abort_q || xfer_abort) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        hold_cnt_d = 16'(SpaceLat);
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                // Stays SpaceLat cycles so SPACE_AVAIL reflects the previous request
                if (xfer_abort) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (hold_cnt_q <= 16'd1) begin
                    if (rem_q != '0) begin
                        state_d = StCalc;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
            req_words_q <= '0;
            main_req_q  <= 1'b0;
            main_len_q  <= '0;
            main_addr_q <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            chunk_q     <= chunk_d;
            req_words_q <= req_words_d;
            main_req_q  <= main_req_d;
            main_len_q  <= main_len_d;
            main_addr_q <= main_addr_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign main_req       = main_req_q;
    assign main_len       = main_len_q;
    assign main_addr      = main_addr_q;
    assign xfer_busy      = (state_q != StIdle);
    assign xfer_done      = done_q;
    assign xfer_req_words = req_words_q;

endmodule

// File: tb/tb_rx_port_read_splitter.sv
// Scoreboard bench for rx_port_read_splitter: a mux model pops expected requests as they
// are presented on MAIN_REQ and acknowledges them with a programmable delay.
module tb_rx_port_read_splitter;

    localparam int SpaceLat = 6;

    typedef struct packed {
        logic [63:0] addr;
        logic [9:0]  len;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        xfer_start;
    logic [63:0] xfer_addr;
    logic [30:0] xfer_len;
    logic        xfer_abort;
    logic [2:0]  max_read;
    logic [15:0] space_avail;
    logic        main_req;
    logic [9:0]  main_len;
    logic [63:0] main_addr;
    logic        main_req_proc;
    logic        xfer_busy;
    logic        xfer_done;
    logic [30:0] xfer_req_words;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   ack_delay = 0;
    int   last_fall = -1;
    req_t sb[$];

    rx_port_read_splitter #(.SpaceLat(SpaceLat)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .xfer_start     (xfer_start),
        .xfer_addr      (xfer_addr),
        .xfer_len       (xfer_len),
        .xfer_abort     (xfer_abort),
        .max_read       (max_read),
        .space_avail    (space_avail),
        .main_req       (main_req),
        .main_len       (main_len),
        .main_addr      (main_addr),
        .main_req_proc  (main_req_proc),
        .xfer_busy      (xfer_busy),
        .xfer_done      (xfer_done),
        .xfer_req_words (xfer_req_words)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned model_chunk(input longint unsigned a, input int unsigned rem,
                                                input int unsigned mr);
        int unsigned cap;
        int unsigned c;
        cap = (mr > 4) ? 4 : mr;
        c   = (rem < (32 << cap)) ? rem : (32 << cap);
`ifdef RXREQ_SPLIT_4K_EN
        if ((1024 - ((a >> 2) & 1023)) < c) c = 1024 - ((a >> 2) & 1023);
`endif
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the start pulse was sampled.
    task automatic start_xfer(input logic [63:0] a, input logic [30:0] len, input logic [2:0] mr,
                              input int max_push);
        longint unsigned ad;
        int unsigned     rem;
        int unsigned     c;
        int              n;
        ad  = a & ~64'h3;
        rem = len;
        n   = 0;
        while (rem > 0 && n < max_push) begin
            c = model_chunk(ad, rem, mr);
            sb.push_back('{addr: ad, len: c[9:0]});
            ad  = ad + c * 4;
            rem = rem - c;
            n++;
        end
        last_fall  = -1;
        xfer_addr  = a;
        xfer_len   = len;
        max_read   = mr;
        xfer_start = 1'b1;
        @(negedge clk);
        xfer_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic [30:0] exp_words);
        int n;
        n = 0;
        while (!xfer_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, xfer_done, 1);
        check_eq({tag, "_busy"}, xfer_busy, 0);
        check_eq({tag, "_words"}, xfer_req_words, exp_words);
        check_eq({tag, "_sb_empty"}, sb.size(), 0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, xfer_done, 0);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (!main_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req_seen"}, main_req, 1);
    endtask

    // Mux model
    initial begin : mux_model
        req_t exp;
        logic have_exp;
        main_req_proc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && main_req && !main_req_proc) begin
                check_eq("req_expected", sb.size() != 0, 1);
                have_exp = (sb.size() != 0);
                if (have_exp) begin
                    exp = sb.pop_front();
                    check_eq("req_addr", main_addr, exp.addr);
                    check_eq("req_len", main_len, 64'(exp.len));
                end
                if (last_fall >= 0) check_eq("req_gap", 64'(cyc - last_fall), 64'(SpaceLat + 3));
                for (int i = 0; i < ack_delay && rst_n; i++) begin
                    @(negedge clk);
                    if (rst_n && have_exp) begin
                        check_eq("hold_req", main_req, 1);
                        check_eq("hold_addr", main_addr, exp.addr);
                        check_eq("hold_len", main_len, 64'(exp.len));
                    end
                end
                if (rst_n) begin
                    main_req_proc = 1'b1;
                    @(negedge clk);
                    check_eq("req_drop", main_req, 0);
                    @(negedge clk);
                    main_req_proc = 1'b0;
                    last_fall = cyc;
                end else begin
                    main_req_proc = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main_seq
        rst_n       = 1'b0;
        xfer_start  = 1'b0;
        xfer_addr   = '0;
        xfer_len    = '0;
        xfer_abort  = 1'b0;
        max_read    = 3'd2;
        space_avail = 16'd1000;
        repeat (3) @(negedge clk);
        check_eq("rst_main_req", main_req, 0);
        check_eq("rst_main_len", main_len, 0);
        check_eq("rst_main_addr", main_addr, 0);
        check_eq("rst_busy", xfer_busy, 0);
        check_eq("rst_done", xfer_done, 0);
        check_eq("rst_words", xfer_req_words, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic split with start-to-request latency
        start_xfer(64'h1000, 31'd300, 3'd2, 100);
        check_eq("lat_calc", main_req, 0);
        check_eq("lat_busy", xfer_busy, 1);
        @(negedge clk);
        check_eq("lat_wait", main_req, 0);
        @(negedge clk);
        check_eq("lat_req", main_req, 1);
        wait_done("basic", 200, 31'd300);

        // Page-boundary case; one or two requests depending on build
        start_xfer(64'h1F80, 31'd100, 3'd4, 100);
        wait_done("page", 200, 31'd100);

        // Space gating
        space_avail = 16'd50;
        start_xfer(64'h0, 31'd128, 3'd2, 100);
        repeat (8) @(negedge clk);
        check_eq("space_gate_req", main_req, 0);
        check_eq("space_gate_busy", xfer_busy, 1);
        space_avail = 16'd200;
        @(negedge clk);
        check_eq("space_release", main_req, 1);
        wait_done("space", 100, 31'd128);
        space_avail = 16'd1000;

        // Delayed acknowledge, odd address bits, MAX_READ saturation-free case; start while busy
        ack_delay = 5;
        start_xfer(64'h8003, 31'd200, 3'd1, 100);
        repeat (4) @(negedge clk);
        xfer_start = 1'b1;
        xfer_addr  = 64'hDEAD_0000;
        xfer_len   = 31'd7;
        @(negedge clk);
        xfer_start = 1'b0;
        wait_done("delay", 300, 31'd200);

        // MAX_READ above cap behaves as 512 words, address wraps past 2^64
        ack_delay = 0;
        start_xfer(64'hFFFF_FFFF_FFFF_FC00, 31'd1024, 3'd7, 100);
        wait_done("wrap", 300, 31'd1024);

        // Abort while a request is pending
        ack_delay = 3;
        start_xfer(64'h4000, 31'd300, 3'd2, 1);
        wait_req("abort_req", 20);
        xfer_abort = 1'b1;
        @(negedge clk);
        xfer_abort = 1'b0;
        wait_done("abort_req", 50, 31'd128);
        repeat (15) @(negedge clk);
        check_eq("abort_req_quiet", main_req, 0);

        // Abort in HOLD
        ack_delay = 0;
        start_xfer(64'h10000, 31'd300, 3'd2, 1);
        begin
            int n;
            n = 0;
            while (xfer_req_words != 31'd128 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("hold_words", xfer_req_words, 128);
        repeat (3) @(negedge clk);
        check_eq("hold_busy", xfer_busy, 1);
        xfer_abort = 1'b1;
        @(negedge clk);
        xfer_abort = 1'b0;
        check_eq("hold_abort_done", xfer_done, 1);
        check_eq("hold_abort_idle", xfer_busy, 0);
        repeat (15) @(negedge clk);
        check_eq("hold_abort_quiet", main_req, 0);
        check_eq("hold_sb_empty", sb.size(), 0);

        // Zero-length descriptor
        start_xfer(64'h2000, 31'd0, 3'd2, 100);
        check_eq("zero_done", xfer_done, 1);
        check_eq("zero_busy", xfer_busy, 0);
        check_eq("zero_req", main_req, 0);
        @(negedge clk);
        check_eq("zero_done_pulse", xfer_done, 0);

        // Reset mid-transfer
        ack_delay = 20;
        start_xfer(64'h3000, 31'd300, 3'd2, 1);
        wait_req("rst_mid", 20);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_req", main_req, 0);
        check_eq("rst_mid_len", main_len, 0);
        check_eq("rst_mid_addr", main_addr, 0);
        check_eq("rst_mid_busy", xfer_busy, 0);
        check_eq("rst_mid_done", xfer_done, 0);
        check_eq("rst_mid_words", xfer_req_words, 0);
        repeat (2) @(negedge clk);
        sb.delete();
        ack_delay = 0;
        rst_n = 1'b1;
        @(negedge clk);

        // Recovery after reset
        start_xfer(64'h20, 31'd10, 3'd0, 100);
        wait_done("recover", 100, 31'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
